// File: rtl/mms_icache.sv
// Direct-mapped blocking instruction cache: 16-byte lines, 4-beat in-order refill.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module mms_icache #(
    parameter int unsigned INDEX_WD = 6,
    parameter int unsigned ADDR_WD  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req_valid,
    output logic                 fetch_req_ready,
    input  logic [ADDR_WD-1:0]   fetch_req_addr,
    input  logic                 flush,
    output logic                 fetch_resp_valid,
    input  logic                 fetch_resp_ready,
    output logic [127:0]         fetch_resp_inst,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_WD-1:0]   mem_req_addr,
    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]          perf_hit_cnt,
    output logic [31:0]          perf_miss_cnt
`endif
);

    localparam int unsigned OFFSET_WD = 4;
    localparam int unsigned TAG_WD    = ADDR_WD - INDEX_WD - OFFSET_WD;
    localparam int unsigned LINES     = 1 << INDEX_WD;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_t;

    state_t                 state_q;
    logic                   rdy_q;
    logic                   hit_q;
    logic                   flush_pend_q;
    logic [1:0]             beat_cnt_q;
    logic [INDEX_WD-1:0]    idx_q;
    logic [TAG_WD-1:0]      tag_q;
    logic [2:0][31:0]       fill_q;
    logic [LINES-1:0]       valid_q;
    logic [TAG_WD-1:0]      tag_arr  [LINES];
    logic [127:0]           data_arr [LINES];

    logic [INDEX_WD-1:0]    req_idx;
    logic [TAG_WD-1:0]      req_tag;
    logic                   lookup_hit;
    logic [127:0]           fill_line;
    logic                   line_wr;
    logic                   flush_any;
    logic                   unused_addr_lsb;

    assign req_idx         = fetch_req_addr[INDEX_WD+OFFSET_WD-1:OFFSET_WD];
    assign req_tag         = fetch_req_addr[ADDR_WD-1:INDEX_WD+OFFSET_WD];
    assign unused_addr_lsb = ^fetch_req_addr[OFFSET_WD-1:0];
    assign lookup_hit      = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign fill_line       = {mem_resp_data, fill_q[2], fill_q[1], fill_q[0]};
    assign line_wr         = !rst && (state_q == REFILL) && mem_resp_valid && (beat_cnt_q == 2'd3);
    assign flush_any       = flush_pend_q || flush;

    // Flush takes priority over a same-cycle request, so readiness drops combinationally.
    assign fetch_req_ready = rdy_q && !flush;

    // Line storage; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (line_wr) begin
            data_arr[idx_q] <= fill_line;
            tag_arr[idx_q]  <= tag_q;
        end
    end

    // Control FSM. The hit decision is taken at accept so the response is registered in LOOKUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            rdy_q            <= 1'b1;
            hit_q            <= 1'b0;
            flush_pend_q     <= 1'b0;
            beat_cnt_q       <= 2'd0;
            idx_q            <= '0;
            tag_q            <= '0;
            fill_q           <= '0;
            valid_q          <= '0;
            fetch_resp_valid <= 1'b0;
            fetch_resp_inst  <= '0;
            mem_req_valid    <= 1'b0;
            mem_req_addr     <= '0;
        end else begin
            if (flush && (state_q != IDLE)) begin
                flush_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (fetch_req_valid) begin
                        idx_q            <= req_idx;
                        tag_q            <= req_tag;
                        hit_q            <= lookup_hit;
                        fetch_resp_valid <= lookup_hit;
                        if (lookup_hit) begin
                            fetch_resp_inst <= data_arr[req_idx];
                        end
                        rdy_q   <= 1'b0;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit_q) begin
                        if (fetch_resp_ready) begin
                            state_q          <= IDLE;
                            rdy_q            <= 1'b1;
                            fetch_resp_valid <= 1'b0;
                            flush_pend_q     <= 1'b0;
                            if (flush_any) begin
                                valid_q <= '0;
                            end
                        end else begin
                            state_q <= RESP;
                        end
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {tag_q, idx_q, 4'b0000};
                        state_q       <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat_cnt_q    <= 2'd0;
                        state_q       <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_resp_valid) begin
                        beat_cnt_q <= beat_cnt_q + 2'd1;
                        case (beat_cnt_q)
                            2'd0: fill_q[0] <= mem_resp_data;
                            2'd1: fill_q[1] <= mem_resp_data;
                            2'd2: fill_q[2] <= mem_resp_data;
                            default: begin
                                valid_q[idx_q]   <= !flush_any;
                                fetch_resp_valid <= 1'b1;
                                fetch_resp_inst  <= fill_line;
                                state_q          <= RESP;
                            end
                        endcase
                    end
                end
                RESP: begin
                    if (fetch_resp_ready) begin
                        state_q          <= IDLE;
                        rdy_q            <= 1'b1;
                        fetch_resp_valid <= 1'b0;
                        flush_pend_q     <= 1'b0;
                        if (flush_any) begin
                            valid_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Lookup outcome counters; survive flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit_cnt  <= 32'd0;
            perf_miss_cnt <= 32'd0;
        end else if (state_q == LOOKUP) begin
            if (hit_q) begin
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            end else begin
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mms_icache.sv
// Self-checking bench for mms_icache: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a tag-dictionary reference model.
module tb_mms_icache;

    logic         clk;
    logic         rst;
    logic         fetch_req_valid;
    logic         fetch_req_ready;
    logic [31:0]  fetch_req_addr;
    logic         flush;
    logic         fetch_resp_valid;
    logic         fetch_resp_ready;
    logic [127:0] fetch_resp_inst;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [31:0]  mem_resp_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  perf_hit_cnt;
    logic [31:0]  perf_miss_cnt;
`endif

    mms_icache dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_req_addr   (fetch_req_addr),
        .flush            (flush),
        .fetch_resp_valid (fetch_resp_valid),
        .fetch_resp_ready (fetch_resp_ready),
        .fetch_resp_inst  (fetch_resp_inst),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit_cnt     (perf_hit_cnt),
        .perf_miss_cnt    (perf_miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int exp_hits;
    int exp_misses;

    // Reference model: which tag each index currently holds, and backing memory.
    bit           m_valid [64];
    logic [21:0]  m_tag   [64];
    logic [31:0]  mem_ovr [logic [31:0]];

    localparam logic [127:0] L1 = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    localparam logic [127:0] L2 = {32'h0000_00A4, 32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1};

    typedef struct {
        logic [31:0]  addr;
        int           mem_wait;
        int           stall;
        bit           flush_first;
        bit           exp_hit;
        logic [127:0] exp_line;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:4], 4'h0};
        return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  128'(fetch_req_ready),  128'd1);
        check({tag, "_resp_valid"}, 128'(fetch_resp_valid), 128'd0);
        check({tag, "_mem_valid"},  128'(mem_req_valid),    128'd0);
        check({tag, "_mem_addr"},   128'(mem_req_addr),     128'd0);
        check({tag, "_inst"},       fetch_resp_inst,        128'd0);
    endtask

    // Drives one fetch end to end while acting as the memory and the consumer.
    task automatic fetch(input logic [31:0] addr, input int mem_wait, input int stall,
                         input bit flush_first, input int flush_beat, input int rst_beat,
                         input bit gaps, output logic [127:0] inst, output bit missed,
                         output int lat, output bit aborted);
        int  wait_left;
        int  beats;
        int  stall_left;
        bit  refilling;
        bit  got;
        bit  done;
        int  cyc;
        logic [31:0] line_addr;
        line_addr = {addr[31:4], 4'h0};
        inst = '0; missed = 1'b0; lat = 0; aborted = 1'b0;
        wait_left = mem_wait; beats = 0; stall_left = 0;
        refilling = 1'b0; got = 1'b0; done = 1'b0;

        @(negedge clk);
        fetch_req_valid = 1'b1;
        fetch_req_addr  = addr;
        if (flush_first) begin
            flush = 1'b1;
            #1;
            check("flush_blocks_req", 128'(fetch_req_ready), 128'd0);
            @(negedge clk);
            flush = 1'b0;
        end
        #1;
        cyc = 0;
        while (!fetch_req_ready && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!fetch_req_ready) begin
            check("req_ready_timeout", 128'(fetch_req_ready), 128'd1);
            fetch_req_valid = 1'b0;
            aborted = 1'b1;
            return;
        end
        @(posedge clk);

        for (cyc = 1; cyc <= 200 && !done; cyc++) begin
            @(negedge clk);
            fetch_req_valid  = 1'b0;
            flush            = 1'b0;
            mem_req_ready    = 1'b0;
            mem_resp_valid   = 1'b0;
            fetch_resp_ready = 1'b0;
            if (mem_req_valid) begin
                missed = 1'b1;
                check("mem_req_addr", 128'(mem_req_addr), 128'(line_addr));
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    mem_req_ready = 1'b1;
                    refilling     = 1'b1;
                end
            end else if (refilling && beats < 4) begin
                if (rst_beat >= 0 && beats == rst_beat) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check_reset_outputs("mid_rst");
                    rst = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = mem_word(line_addr + 32'd12);
                        @(negedge clk);
                        check("stray_resp_valid", 128'(fetch_resp_valid), 128'd0);
                        check("stray_mem_valid",  128'(mem_req_valid),    128'd0);
                    end
                    mem_resp_valid = 1'b0;
                    aborted = 1'b1;
                    return;
                end
                if (!(gaps && $urandom_range(0, 2) == 0)) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(line_addr + 32'(beats * 4));
                    if (beats == flush_beat) flush = 1'b1;
                    beats++;
                end
            end
            if (fetch_resp_valid) begin
                if (!got) begin
                    got        = 1'b1;
                    inst       = fetch_resp_inst;
                    lat        = cyc;
                    stall_left = stall;
                end else begin
                    check("resp_inst_stable", fetch_resp_inst, inst);
                    check("req_ready_in_resp", 128'(fetch_req_ready), 128'd0);
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    fetch_resp_ready = 1'b1;
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            check("resp_timeout", 128'(got), 128'd2);
            aborted = 1'b1;
            return;
        end
        @(negedge clk);
        fetch_resp_ready = 1'b0;
        mem_resp_valid   = 1'b0;
        check("resp_release", 128'(fetch_resp_valid), 128'd0);
    endtask

    // Runs a fetch, compares against the table expectation or the model, then updates the model.
    task automatic run_txn(input string name, input logic [31:0] addr, input int mem_wait,
                           input int stall, input bit flush_first, input int flush_beat,
                           input int rst_beat, input bit gaps, input bit use_exp,
                           input bit exp_hit, input logic [127:0] exp_line);
        logic [5:0]   idx;
        logic [21:0]  tag;
        bit           pred_hit;
        logic [127:0] inst;
        bit           missed;
        int           lat;
        bit           aborted;
        idx = addr[9:4];
        tag = addr[31:10];
        if (flush_first) model_flush();
        pred_hit = m_valid[idx] && (m_tag[idx] == tag);
        fetch(addr, mem_wait, stall, flush_first, flush_beat, rst_beat, gaps,
              inst, missed, lat, aborted);
        if (aborted) begin
            if (rst_beat >= 0) begin
                model_flush();
                exp_hits   = 0;
                exp_misses = 0;
            end
            return;
        end
        if (use_exp) begin
            check({name, "_hit"},  128'(!missed), 128'(exp_hit));
            check({name, "_inst"}, inst, exp_line);
        end else begin
            check({name, "_hit"},  128'(!missed), 128'(pred_hit));
            check({name, "_inst"}, inst, line_of(addr));
        end
        if (!missed) check({name, "_hit_latency"}, 128'(lat), 128'd1);
        if (pred_hit) exp_hits++; else exp_misses++;
        if (!pred_hit) begin
            m_tag[idx]   = tag;
            m_valid[idx] = 1'b1;
            if (flush_beat >= 0 && flush_beat <= 3) model_flush();
        end
    endtask

    initial begin
        checks = 0; failures = 0; exp_hits = 0; exp_misses = 0;
        model_flush();
        for (int i = 0; i < 64; i++) m_tag[i] = '0;
        for (int k = 0; k < 4; k++) begin
            mem_ovr[32'h1000 + 32'(k * 4)] = 32'h11 * 32'(k + 1);
            mem_ovr[32'h2000 + 32'(k * 4)] = 32'hA1 + 32'(k);
        end

        vecs[0] = '{32'h0000_1000, 0, 0, 1'b0, 1'b0, L1};
        vecs[1] = '{32'h0000_100C, 0, 0, 1'b0, 1'b1, L1};
        vecs[2] = '{32'h0000_2000, 2, 0, 1'b0, 1'b0, L2};
        vecs[3] = '{32'h0000_1000, 0, 0, 1'b0, 1'b0, L1};
        vecs[4] = '{32'h0000_1004, 0, 5, 1'b0, 1'b1, L1};
        vecs[5] = '{32'h0000_2008, 1, 0, 1'b0, 1'b0, L2};
        vecs[6] = '{32'h0000_1000, 0, 0, 1'b1, 1'b0, L1};
        vecs[7] = '{32'h0000_1008, 0, 2, 1'b0, 1'b1, L1};

        rst = 1'b1;
        fetch_req_valid = 1'b0; fetch_req_addr = '0; flush = 1'b0;
        fetch_resp_ready = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        for (int v = 0; v < 8; v++) begin
            run_txn($sformatf("vec%0d", v), vecs[v].addr, vecs[v].mem_wait, vecs[v].stall,
                    vecs[v].flush_first, -1, -1, 1'b0, 1'b1, vecs[v].exp_hit, vecs[v].exp_line);
        end

        // Flush during beat 1: response still delivered, nothing left valid afterwards.
        run_txn("flush_mid",       32'h0000_3000, 0, 0, 1'b0, 1, -1, 1'b0, 1'b1, 1'b0, line_of(32'h3000));
        run_txn("after_flush",     32'h0000_3000, 0, 0, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0, line_of(32'h3000));
        run_txn("after_flush_old", 32'h0000_1000, 0, 0, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0, L1);
        run_txn("refill_hit",      32'h0000_1004, 0, 0, 1'b0, -1, -1, 1'b0, 1'b1, 1'b1, L1);

        // Reset after three beats of a refill, then stray beats, then the same address again.
        run_txn("rst_mid",   32'h0000_4000, 1, 0, 1'b0, -1, 3, 1'b0, 1'b0, 1'b0, '0);
        run_txn("after_rst", 32'h0000_4000, 0, 0, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0, line_of(32'h4000));
        run_txn("after_rst2", 32'h0000_1000, 0, 0, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0, L1);

        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            bit          ff;
            int          fb;
            a  = 32'h0001_0000 + 32'($urandom_range(0, 3)) * 32'h400
                 + 32'($urandom_range(0, 3)) * 32'h10 + 32'($urandom_range(0, 15));
            ff = ($urandom_range(0, 7) == 0);
            fb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_txn("rand", a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ff, fb, -1, 1'b1, 1'b0, 1'b0, '0);
        end

`ifdef ICACHE_PERF_CNT_EN
        check("perf_hit_cnt",  128'(perf_hit_cnt),  128'(exp_hits));
        check("perf_miss_cnt", 128'(perf_miss_cnt), 128'(exp_misses));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
